// File: rtl/pc_fetch_unit.sv
// rtl/pc_fetch_unit.sv - IF-stage PC register, next-PC select and ID-stage PC/valid tracking
// Optional build macro: PC_PERF_CNT_EN adds redirect/stall counters with cnt_clr.
module pc_fetch_unit #(
   parameter int                XLEN     = 32,
   parameter logic [XLEN-1:0]   RESET_PC = 32'h4000_0000
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            stall,
   input  logic [1:0]      PCSel,
   input  logic [XLEN-1:0] jal_target,
   input  logic [XLEN-1:0] br_target,
`ifdef PC_PERF_CNT_EN
   input  logic            cnt_clr,
   output logic [31:0]     redirect_cnt,
   output logic [31:0]     stall_cnt,
`endif
   output logic [XLEN-1:0] pc_if,
   output logic [XLEN-1:0] pc_id,
   output logic            valid_id,
   output logic            flush_id,
   output logic            redirect
);

   typedef enum logic [1:0] {
      ST_BOOT  = 2'd0,
      ST_RUN   = 2'd1,
      ST_FLUSH = 2'd2
   } state_t;

   state_t          state;
   state_t          state_nxt;
   logic            advance;
   logic [XLEN-1:0] target_sel;
   logic [XLEN-1:0] target_aligned;

   // PCSel 11 falls through to the branch/JALR target; low two bits are dropped
   assign target_sel     = (PCSel == 2'b01) ? jal_target : br_target;
   assign target_aligned = target_sel & {{(XLEN-2){1'b1}}, 2'b00};

   // State register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= ST_BOOT;
      end else begin
         state <= state_nxt;
      end
   end

   // Next-state: BOOT always leaves, RUN enters FLUSH on a taken redirect, FLUSH waits out stalls
   always_comb begin
      state_nxt = state;
      case (state)
         ST_BOOT:  state_nxt = ST_RUN;
         ST_RUN:   if (!stall && (PCSel != 2'b00)) state_nxt = ST_FLUSH;
         ST_FLUSH: if (!stall) state_nxt = ST_RUN;
         default:  state_nxt = ST_BOOT;
      endcase
   end

   // Outputs: ID validity follows RUN; redirect and pipeline advance are decoded from state
   always_comb begin
      valid_id = 1'b0;
      flush_id = 1'b1;
      redirect = 1'b0;
      advance  = 1'b0;
      case (state)
         ST_BOOT: begin
            advance = 1'b1;
         end
         ST_RUN: begin
            valid_id = 1'b1;
            flush_id = 1'b0;
            redirect = !stall && (PCSel != 2'b00);
            advance  = !stall;
         end
         ST_FLUSH: begin
            advance = !stall;
         end
         default: begin
            advance = 1'b0;
         end
      endcase
   end

   // PC pipeline: on advance the fetched PC moves to ID and pc_if takes target or PC+4
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pc_if <= RESET_PC;
         pc_id <= '0;
      end else if (advance) begin
         pc_id <= pc_if;
         pc_if <= redirect ? target_aligned : (pc_if + XLEN'(4));
      end
   end

`ifdef PC_PERF_CNT_EN
   // Event counters; clear beats increment, stalls in BOOT are not counted
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         redirect_cnt <= '0;
         stall_cnt    <= '0;
      end else if (cnt_clr) begin
         redirect_cnt <= '0;
         stall_cnt    <= '0;
      end else begin
         if (redirect) redirect_cnt <= redirect_cnt + 32'd1;
         if (stall && (state != ST_BOOT)) stall_cnt <= stall_cnt + 32'd1;
      end
   end
`endif

endmodule

// File: tb/tb_pc_fetch_unit.sv
// tb/tb_pc_fetch_unit.sv - directed vector bench for pc_fetch_unit
module tb_pc_fetch_unit;

   logic        clk;
   logic        rst;
   logic        stall;
   logic [1:0]  PCSel;
   logic [31:0] jal_target;
   logic [31:0] br_target;
   logic [31:0] pc_if;
   logic [31:0] pc_id;
   logic        valid_id;
   logic        flush_id;
   logic        redirect;
`ifdef PC_PERF_CNT_EN
   logic        cnt_clr;
   logic [31:0] redirect_cnt;
   logic [31:0] stall_cnt;
`endif

   int total;
   int bad;

   typedef struct {
      logic        stall;
      logic [1:0]  sel;
      logic [31:0] jal;
      logic [31:0] br;
      logic [31:0] e_if;
      logic [31:0] e_id;
      logic        e_v;
      logic        e_f;
      logic        e_r;
   } vec_t;

   vec_t vecs[20];

   pc_fetch_unit #(.XLEN(32), .RESET_PC(32'h4000_0000)) dut (
      .clk        (clk),
      .rst        (rst),
      .stall      (stall),
      .PCSel      (PCSel),
      .jal_target (jal_target),
      .br_target  (br_target),
`ifdef PC_PERF_CNT_EN
      .cnt_clr      (cnt_clr),
      .redirect_cnt (redirect_cnt),
      .stall_cnt    (stall_cnt),
`endif
      .pc_if      (pc_if),
      .pc_id      (pc_id),
      .valid_id   (valid_id),
      .flush_id   (flush_id),
      .redirect   (redirect)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic chk_regs(input string tag, input logic [31:0] e_if, input logic [31:0] e_id,
                           input logic e_v, input logic e_f);
      chk({tag, ".pc_if"}, pc_if, e_if);
      chk({tag, ".pc_id"}, pc_id, e_id);
      chk({tag, ".valid_id"}, {31'd0, valid_id}, {31'd0, e_v});
      chk({tag, ".flush_id"}, {31'd0, flush_id}, {31'd0, e_f});
   endtask

   // one cycle: drive, check redirect before the edge, check registers after it
   task automatic step(input logic s, input logic [1:0] sel, input logic [31:0] j,
                       input logic [31:0] b, input logic e_r);
      stall      = s;
      PCSel      = sel;
      jal_target = j;
      br_target  = b;
      #1;
      chk("redirect", {31'd0, redirect}, {31'd0, e_r});
      @(posedge clk);
      #1;
   endtask

   initial begin
      total = 0;
      bad   = 0;
      rst = 1'b1; stall = 1'b0; PCSel = 2'b00; jal_target = '0; br_target = '0;
`ifdef PC_PERF_CNT_EN
      cnt_clr = 1'b0;
`endif

      vecs[0]  = '{1'b0, 2'd0, 32'h0,         32'h0,         32'h4000_0004, 32'h4000_0000, 1'b1, 1'b0, 1'b0};
      vecs[1]  = '{1'b0, 2'd0, 32'h0,         32'h0,         32'h4000_0008, 32'h4000_0004, 1'b1, 1'b0, 1'b0};
      vecs[2]  = '{1'b0, 2'd0, 32'h0,         32'h0,         32'h4000_000C, 32'h4000_0008, 1'b1, 1'b0, 1'b0};
      vecs[3]  = '{1'b0, 2'd0, 32'h0,         32'h0,         32'h4000_0010, 32'h4000_000C, 1'b1, 1'b0, 1'b0};
      vecs[4]  = '{1'b0, 2'd1, 32'h4000_0100, 32'h0,         32'h4000_0100, 32'h4000_0010, 1'b0, 1'b1, 1'b1};
      vecs[5]  = '{1'b0, 2'd1, 32'h4000_0300, 32'h0,         32'h4000_0104, 32'h4000_0100, 1'b1, 1'b0, 1'b0};
      vecs[6]  = '{1'b0, 2'd2, 32'h0,         32'h4000_0203, 32'h4000_0200, 32'h4000_0104, 1'b0, 1'b1, 1'b1};
      vecs[7]  = '{1'b0, 2'd0, 32'h0,         32'h0,         32'h4000_0204, 32'h4000_0200, 1'b1, 1'b0, 1'b0};
      vecs[8]  = '{1'b0, 2'd3, 32'h4000_0900, 32'h4000_0402, 32'h4000_0400, 32'h4000_0204, 1'b0, 1'b1, 1'b1};
      vecs[9]  = '{1'b0, 2'd0, 32'h0,         32'h0,         32'h4000_0404, 32'h4000_0400, 1'b1, 1'b0, 1'b0};
      vecs[10] = '{1'b1, 2'd2, 32'h0,         32'h4000_0800, 32'h4000_0404, 32'h4000_0400, 1'b1, 1'b0, 1'b0};
      vecs[11] = '{1'b1, 2'd2, 32'h0,         32'h4000_0800, 32'h4000_0404, 32'h4000_0400, 1'b1, 1'b0, 1'b0};
      vecs[12] = '{1'b1, 2'd2, 32'h0,         32'h4000_0800, 32'h4000_0404, 32'h4000_0400, 1'b1, 1'b0, 1'b0};
      vecs[13] = '{1'b0, 2'd2, 32'h0,         32'h4000_0800, 32'h4000_0800, 32'h4000_0404, 1'b0, 1'b1, 1'b1};
      vecs[14] = '{1'b1, 2'd0, 32'h0,         32'h0,         32'h4000_0800, 32'h4000_0404, 1'b0, 1'b1, 1'b0};
      vecs[15] = '{1'b1, 2'd1, 32'h4000_0900, 32'h0,         32'h4000_0800, 32'h4000_0404, 1'b0, 1'b1, 1'b0};
      vecs[16] = '{1'b0, 2'd0, 32'h0,         32'h0,         32'h4000_0804, 32'h4000_0800, 1'b1, 1'b0, 1'b0};
      vecs[17] = '{1'b0, 2'd1, 32'hFFFF_FFFD, 32'h0,         32'hFFFF_FFFC, 32'h4000_0804, 1'b0, 1'b1, 1'b1};
      vecs[18] = '{1'b0, 2'd0, 32'h0,         32'h0,         32'h0000_0000, 32'hFFFF_FFFC, 1'b1, 1'b0, 1'b0};
      vecs[19] = '{1'b0, 2'd0, 32'h0,         32'h0,         32'h0000_0004, 32'h0000_0000, 1'b1, 1'b0, 1'b0};

      // reset state
      @(posedge clk);
      @(posedge clk);
      #1;
      chk_regs("reset", 32'h4000_0000, 32'h0, 1'b0, 1'b1);
      chk("reset.redirect", {31'd0, redirect}, 32'd0);
      rst = 1'b0;

      for (int i = 0; i < 20; i++) begin
         step(vecs[i].stall, vecs[i].sel, vecs[i].jal, vecs[i].br, vecs[i].e_r);
         chk_regs($sformatf("vec%0d", i), vecs[i].e_if, vecs[i].e_id, vecs[i].e_v, vecs[i].e_f);
      end

      // async reset while in FLUSH, applied between clock edges
      step(1'b0, 2'd2, 32'h0, 32'h4000_1000, 1'b1);
      chk_regs("pre_rst_flush", 32'h4000_1000, 32'h0000_0004, 1'b0, 1'b1);
      #1;
      rst = 1'b1;
      #1;
      chk_regs("async_rst", 32'h4000_0000, 32'h0, 1'b0, 1'b1);
      @(posedge clk);
      #1;
      rst = 1'b0;
      step(1'b0, 2'd1, 32'h4000_5000, 32'h0, 1'b0);
      chk_regs("post_rst_boot", 32'h4000_0004, 32'h4000_0000, 1'b1, 1'b0);

`ifdef PC_PERF_CNT_EN
      cnt_clr = 1'b1;
      step(1'b0, 2'd0, 32'h0, 32'h0, 1'b0);
      cnt_clr = 1'b0;
      chk("cnt_clr0.redirect_cnt", redirect_cnt, 32'd0);
      chk("cnt_clr0.stall_cnt", stall_cnt, 32'd0);
      for (int k = 0; k < 3; k++) step(1'b1, 2'd2, 32'h0, 32'h4000_2000, 1'b0);
      step(1'b0, 2'd1, 32'h4000_3000, 32'h0, 1'b1);
      for (int k = 0; k < 2; k++) step(1'b1, 2'd0, 32'h0, 32'h0, 1'b0);
      step(1'b0, 2'd0, 32'h0, 32'h0, 1'b0);
      step(1'b0, 2'd2, 32'h0, 32'h4000_4000, 1'b1);
      step(1'b0, 2'd0, 32'h0, 32'h0, 1'b0);
      chk("perf.redirect_cnt", redirect_cnt, 32'd2);
      chk("perf.stall_cnt", stall_cnt, 32'd5);
      cnt_clr = 1'b1;
      step(1'b1, 2'd0, 32'h0, 32'h0, 1'b0);
      cnt_clr = 1'b0;
      chk("cnt_clr1.redirect_cnt", redirect_cnt, 32'd0);
      chk("cnt_clr1.stall_cnt", stall_cnt, 32'd0);
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
